// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer.
//   DATA_W  - operand / result / switch width
//   SEL_W   - ALU opcode width
//   state_t - sequencer state encoding. The encoding is visible on the
//             stage output, so these values must not change.
package alu_operand_sequencer_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RES = 2'd3
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debouncer and rising-edge
// pulse generator.
//   clk     - system clock
//   rst     - synchronous active-high reset (clears all state)
//   btn_raw - raw, asynchronous, bouncing button input
//   level   - debounced button level
//   pulse   - one-cycle pulse on each debounced rising edge
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             pulse_reg;
  logic [CNT_W-1:0] count_reg;

  // The counter tracks how many consecutive cycles the synchronized input
  // has disagreed with the accepted level. Any agreement restarts it.
  // The level flips on the DEBOUNCE_CYCLES-th disagreeing cycle, and the
  // pulse is raised on the same edge when the new level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      pulse_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      pulse_reg <= 1'b0;
      if (sync2_reg != level_reg) begin
        if (count_reg == CNT_LAST) begin
          level_reg <= sync2_reg;
          pulse_reg <= sync2_reg;
          count_reg <= '0;
        end else begin
          count_reg <= count_reg + 1'b1;
        end
      end else begin
        count_reg <= '0;
      end
    end
  end

  assign level = level_reg;
  assign pulse = pulse_reg;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects two operands and an opcode from the board switches, one per
// "enter" press, presents them to an external ALU, and captures the ALU
// result for display. "clear" abandons the sequence and zeroes everything.
//   clk          - system clock
//   rst          - synchronous active-high reset
//   sw           - switch value (operand or opcode source, live LED preview)
//   btn_enter    - raw enter button
//   btn_clear    - raw clear button
//   A, B         - registered operands to the ALU
//   ALU_Sel      - registered opcode to the ALU
//   alu_out      - ALU result (combinational, from the ALU)
//   alu_carry    - ALU carry-out (combinational, from the ALU)
//   led          - captured result while valid, otherwise sw
//   led_carry    - captured carry bit
//   stage        - current state code
//   result_valid - high while a captured result is held
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_enter,
  input  logic              btn_clear,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [SEL_W-1:0]  ALU_Sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic [DATA_W-1:0] led,
  output logic              led_carry,
  output logic [1:0]        stage,
  output logic              result_valid
);

  // Index 0 = enter, index 1 = clear.
  logic [1:0] btn_raw_vec;
  logic [1:0] btn_level_unused;
  logic [1:0] btn_pulse_vec;

  assign btn_raw_vec = {btn_clear, btn_enter};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw_vec[gi]),
        .level  (btn_level_unused[gi]),
        .pulse  (btn_pulse_vec[gi])
      );
    end
  endgenerate

  logic enter_p;
  logic clear_p;
  assign enter_p = btn_pulse_vec[0];
  assign clear_p = btn_pulse_vec[1];

  state_t            state_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [DATA_W-1:0] res_reg;
  logic              carry_reg;
  logic              valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_A;
      a_reg     <= '0;
      b_reg     <= '0;
      sel_reg   <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else if (clear_p) begin
      // clear takes priority over a coincident enter
      state_reg <= S_A;
      a_reg     <= '0;
      b_reg     <= '0;
      sel_reg   <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_A: begin
          if (enter_p) begin
            a_reg     <= sw;
            state_reg <= S_B;
          end
        end
        S_B: begin
          if (enter_p) begin
            b_reg     <= sw;
            state_reg <= S_OP;
          end
        end
        S_OP: begin
          if (enter_p) begin
            sel_reg   <= sw[SEL_W-1:0];
            state_reg <= S_RES;
          end
        end
        S_RES: begin
          // First cycle here: the ALU has seen the new opcode for a full
          // cycle, so capture. An enter on this cycle is dropped.
          if (!valid_reg) begin
            res_reg   <= alu_out;
            carry_reg <= alu_carry;
            valid_reg <= 1'b1;
          end else if (enter_p) begin
            valid_reg <= 1'b0;
            state_reg <= S_A;
          end
        end
        default: state_reg <= S_A;
      endcase
    end
  end

  assign A            = a_reg;
  assign B            = b_reg;
  assign ALU_Sel      = sel_reg;
  assign led_carry    = carry_reg;
  assign result_valid = valid_reg;
  assign stage        = state_reg;
  assign led          = valid_reg ? res_reg : sw;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [7:0] A, B;
  logic [3:0] ALU_Sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic [7:0] led;
  logic       led_carry;
  logic [1:0] stage;
  logic       result_valid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .btn_enter   (btn_enter),
    .btn_clear   (btn_clear),
    .A           (A),
    .B           (B),
    .ALU_Sel     (ALU_Sel),
    .alu_out     (alu_out),
    .alu_carry   (alu_carry),
    .led         (led),
    .led_carry   (led_carry),
    .stage       (stage),
    .result_valid(result_valid)
  );

  // Attached ALU: {carry, result}
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] s);
    case (s)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign {alu_carry, alu_out} = alu_f(A, B, ALU_Sel);

  // Transaction-level reference model
  int         m_stage;
  logic [7:0] m_a, m_b, m_res;
  logic [3:0] m_sel;
  logic       m_carry, m_rv;

  function automatic void model_reset();
    m_stage = 0; m_a = 0; m_b = 0; m_sel = 0; m_res = 0; m_carry = 0; m_rv = 0;
  endfunction

  function automatic void model_enter(input logic [7:0] v);
    case (m_stage)
      0: begin m_a = v; m_stage = 1; end
      1: begin m_b = v; m_stage = 2; end
      2: begin
        m_sel = v[3:0];
        {m_carry, m_res} = alu_f(m_a, m_b, m_sel);
        m_rv = 1; m_stage = 3;
      end
      default: begin m_rv = 0; m_stage = 0; end
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".stage"}, 32'(stage), 32'(m_stage));
    check({tag, ".A"}, 32'(A), 32'(m_a));
    check({tag, ".B"}, 32'(B), 32'(m_b));
    check({tag, ".ALU_Sel"}, 32'(ALU_Sel), 32'(m_sel));
    check({tag, ".led"}, 32'(led), m_rv ? 32'(m_res) : 32'(sw));
    check({tag, ".led_carry"}, 32'(led_carry), 32'(m_carry));
    check({tag, ".result_valid"}, 32'(result_valid), 32'(m_rv));
  endtask

  // Clean press: long enough to debounce both edges
  task automatic press_enter(input logic [7:0] v);
    sw = v;
    btn_enter = 1'b1; tick(12);
    btn_enter = 1'b0; tick(12);
    model_enter(v);
  endtask

  task automatic press_clear();
    btn_clear = 1'b1; tick(12);
    btn_clear = 1'b0; tick(12);
    model_reset();
  endtask

  // Opcode press that also checks the two-cycle capture latency
  task automatic press_enter_timed(input logic [7:0] v);
    int waited;
    bit seen;
    sw = v;
    btn_enter = 1'b1;
    seen = 0;
    waited = 0;
    while (!seen && waited < 30) begin
      tick(1);
      waited++;
      if (stage == 2'd3) seen = 1;
    end
    check("cap_reach_res", 32'(seen), 32'd1);
    check("cap_rv_first_cycle", 32'(result_valid), 32'd0);
    tick(1);
    check("cap_rv_second_cycle", 32'(result_valid), 32'd1);
    tick(12 - waited > 0 ? 12 - waited : 1);
    btn_enter = 1'b0; tick(12);
    model_enter(v);
  endtask

  typedef struct {
    logic [7:0] a_sw;
    logic [7:0] b_sw;
    logic [7:0] op_sw;
    logic [3:0] exp_sel;
    logic [7:0] exp_led;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 8'h00, 4'h0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 4'h0, 8'h00, 1'b1};
    vecs[2] = '{8'h0F, 8'h03, 8'hF1, 4'h1, 8'h0C, 1'b0};
    vecs[3] = '{8'h3C, 8'h0F, 8'h52, 4'h2, 8'h0C, 1'b0};

    rst = 1'b1; sw = 8'h00; btn_enter = 1'b0; btn_clear = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    model_reset();
    check_all("reset");
    $display("txn reset: stage=%0d led=0x%02h", stage, led);

    // Table-driven full sequences, each followed by the return press
    for (int i = 0; i < 4; i++) begin
      press_enter(vecs[i].a_sw);
      press_enter(vecs[i].b_sw);
      press_enter_timed(vecs[i].op_sw);
      check($sformatf("vec%0d.led", i), 32'(led), 32'(vecs[i].exp_led));
      check($sformatf("vec%0d.carry", i), 32'(led_carry), 32'(vecs[i].exp_carry));
      check($sformatf("vec%0d.sel", i), 32'(ALU_Sel), 32'(vecs[i].exp_sel));
      check_all($sformatf("vec%0d", i));
      $display("txn vec%0d: A=0x%02h B=0x%02h sel=%0h led=0x%02h carry=%0b",
               i, A, B, ALU_Sel, led, led_carry);
      press_enter(8'hA5);
      check_all($sformatf("ret%0d", i));
      check($sformatf("ret%0d.led_is_sw", i), 32'(led), 32'h0000_00A5);
      $display("txn ret%0d: stage=%0d led=0x%02h", i, stage, led);
    end

    // Enter and clear together in S_OP
    press_enter(8'h12);
    press_enter(8'h34);
    check("simul.pre_stage", 32'(stage), 32'd2);
    sw = 8'h07;
    btn_enter = 1'b1; btn_clear = 1'b1; tick(12);
    btn_enter = 1'b0; btn_clear = 1'b0; tick(12);
    model_reset();
    check_all("simul");
    $display("txn simul: stage=%0d A=0x%02h B=0x%02h rv=%0b", stage, A, B, result_valid);

    // Bounce rejection: short highs, then a long hold
    sw = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      btn_enter = 1'b1; tick(3);
      btn_enter = 1'b0; tick(3);
    end
    tick(4);
    check("bounce.no_advance", 32'(stage), 32'd0);
    btn_enter = 1'b1; tick(20);
    btn_enter = 1'b0; tick(12);
    model_enter(8'h3C);
    check_all("bounce");
    $display("txn bounce: stage=%0d A=0x%02h", stage, A);

    // Mid-operation reset with a button held through it
    press_clear();
    press_enter(8'h55);
    check("mrst.pre_stage", 32'(stage), 32'd1);
    check("mrst.pre_A", 32'(A), 32'h55);
    sw = 8'h33;
    btn_enter = 1'b1;
    rst = 1'b1; tick(4);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check($sformatf("mrst.hold%0d.stage", k), 32'(stage), 32'd0);
      check($sformatf("mrst.hold%0d.A", k), 32'(A), 32'd0);
    end
    tick(10);
    model_enter(8'h33);
    check_all("mrst.late_pulse");
    btn_enter = 1'b0; tick(12);
    check_all("mrst");
    $display("txn mrst: stage=%0d A=0x%02h", stage, A);

    // Randomized presses against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        press_clear();
        check_all($sformatf("rnd%0d", i));
        $display("txn rnd%0d: clear stage=%0d", i, stage);
      end else begin
        press_enter(8'($urandom));
        check_all($sformatf("rnd%0d", i));
        $display("txn rnd%0d: enter sw=0x%02h stage=%0d led=0x%02h carry=%0b rv=%0b",
                 i, sw, stage, led, led_carry, result_valid);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 500000, the number of consecutive stable cycles required before a button level is accepted (minimum 2).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  in  1  system clock; every register updates on its rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: sw  in  8  board switch value, used as operand or opcode source.
REQ-006 Port: btn_enter  in  1  raw, asynchronous, bouncing "enter" push-button.
REQ-007 Port: btn_clear  in  1  raw, asynchronous, bouncing "clear" push-button.
REQ-008 Port: A  out  8  registered operand A driven to the downstream ALU.
REQ-009 Port: B  out  8  registered operand B driven to the downstream ALU.
REQ-010 Port: ALU_Sel  out  4  registered opcode driven to the downstream ALU.
REQ-011 Port: alu_out  in  8  combinational ALU result, returned from the ALU.
REQ-012 Port: alu_carry  in  1  combinational ALU carry-out, returned from the ALU.
REQ-013 Port: led  out  8  display value for the board LEDs.
REQ-014 Port: led_carry  out  1  registered carry bit for display.
REQ-015 Port: stage  out  2  current FSM state code.
REQ-016 Port: result_valid  out  1  high while a captured result is held.

Function
REQ-017 Each button SHALL pass through a 2-flop synchronizer and then a debouncer.
REQ-018 The debounced level SHALL change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch shorter than that resets the count.
REQ-019 A rising edge of a debounced level SHALL produce exactly one 1-cycle pulse (enter_p or clear_p); a held button SHALL produce no further pulses.
REQ-020 FSM states SHALL be S_A=0, S_B=1, S_OP=2, S_RES=3, and stage SHALL equal the current state.
REQ-021 In S_A, enter_p SHALL load A<=sw and move the FSM to S_B.
REQ-022 In S_B, enter_p SHALL load B<=sw and move the FSM to S_OP.
REQ-023 In S_OP, enter_p SHALL load ALU_Sel<=sw[3:0] (sw[7:4] ignored) and move the FSM to S_RES.
REQ-024 On the first cycle in S_RES with result_valid=0, the block SHALL register alu_out into res and alu_carry into led_carry, and set result_valid=1 on the next edge; the result is therefore available 2 cycles after the S_OP enter_p.
REQ-025 An enter_p arriving on that capture cycle SHALL be ignored.
REQ-026 In S_RES with result_valid=1, enter_p SHALL clear result_valid and move the FSM to S_A; A, B and ALU_Sel SHALL be retained until overwritten.
REQ-027 clear_p in any state SHALL zero A, B, ALU_Sel, res, led_carry and result_valid and force the FSM to S_A.
REQ-028 If clear_p and enter_p occur in the same cycle, clear_p SHALL win.
REQ-029 led SHALL equal res when result_valid=1, and sw otherwise (live operand preview).
REQ-030 No arithmetic SHALL be done in this block; all values pass through unmodified at their stated widths.

Reset
REQ-031 rst SHALL set: FSM=S_A, A=B=0, ALU_Sel=0, res=0, led_carry=0, result_valid=0, both debounced levels=0, both debounce counters=0 and both synchronizer flops=0.
REQ-032 rst asserted mid-operation (any state, including the capture cycle) SHALL abandon the operation with no pulse or capture occurring on that edge.
REQ-033 A button held through reset release SHALL produce a pulse only after DEBOUNCE_CYCLES stable cycles following release.

Structure
REQ-034 A shared package SHALL hold the state encoding (S_A..S_RES), DATA_W=8 and SEL_W=4.
REQ-035 The synchronizer, debouncer and edge detector SHALL be one sub-module, btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, btn_raw, level, pulse), instantiated twice.
REQ-036 The debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification (DEBOUNCE_CYCLES=4, ALU model attached)
REQ-037 Full sequence: sw=0x0F enter, sw=0x01 enter, sw=0x0 enter -> A=0x0F, B=0x01, ALU_Sel=0, led=0x10, led_carry=0, result_valid=1 two cycles after the third pulse.
REQ-038 Carry case: A=0xFF, B=0x01, ALU_Sel=0 -> led=0x00, led_carry=1.
REQ-039 Bounce rejection: btn_enter toggles with 3-cycle highs, then is held high 20 cycles -> exactly one enter_p, and stage advances by exactly one.
REQ-040 Simultaneous buttons: enter and clear debounce on the same cycle in S_OP -> stage=0, all registers 0, result_valid=0.
REQ-041 Return path: enter in S_RES -> stage=0, result_valid=0, led=sw, A/B/ALU_Sel unchanged.
REQ-042 Mid-operation reset: rst pulse while in S_B with A=0x55 -> stage=0, A=0, and no pulse from a button held through the reset.
